branch_predict_ctrl: RTL and testbench
======================================

# branch_predict_ctrl

Branch prediction and redirect controller for the pipelined RV32I core. It holds a direct-mapped branch target buffer with 2-bit saturating counters and supplies a predicted next-PC to the IF stage. It compares each EX-stage branch/JAL outcome (the comparator's taken result) against the prediction that travelled down the pipe. On a mismatch it issues a one-cycle redirect plus flush of IF/ID and ID/EX.

## Interface
Parameters:
- IDX_W, 4, log2 of table entries (16 entries); index = pc[IDX_W+1:2]
- PC_W, 32, PC width; tag = pc[PC_W-1:IDX_W+2]

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_pc  in  PC_W  PC being fetched this cycle
- if_pred_taken  out  1  combinational prediction for if_pc
- if_pred_target  out  PC_W  predicted target, valid when if_pred_taken=1
- ex_valid  in  1  EX stage holds a real instruction
- ex_branch  in  1  EX instruction is a conditional branch
- ex_jal  in  1  EX instruction is JAL (JALR is not predicted; handled elsewhere)
- ex_taken  in  1  resolved condition from the branch comparator
- ex_pc  in  PC_W  PC of EX instruction
- ex_target  in  PC_W  computed branch/JAL target
- ex_pred_taken  in  1  prediction carried with the instruction
- ex_pred_target  in  PC_W  predicted target carried with the instruction
- stall  in  1  pipeline hold; EX contents will be re-presented
- redirect_valid  out  1  load redirect_pc into PC this cycle
- redirect_pc  out  PC_W  corrected fetch address
- flush  out  1  squash IF/ID and ID/EX this cycle
- stat_branches  out  32  resolved branch+JAL count
- stat_mispredicts  out  32  mispredict count

## Operation
- Entry fields: valid, tag, target[PC_W-1:0], ctr[1:0].
- Reset: every entry is set to valid=0, ctr=2'b01 (weakly not-taken), tag=0, target=0.
- Lookup is combinational. if_pred_taken = valid & (tag==if_pc tag) & ctr[1]. if_pred_target = entry target. When if_pred_taken=0, if_pred_target is don't-care but driven to 0.
- Resolve condition: state RUN & ex_valid & (ex_branch | ex_jal) & ~stall.
- actual = ex_jal ? 1 : ex_taken.
- mispredict = (actual != ex_pred_taken) | (actual & ex_pred_taken & ex_pred_target != ex_target).
- Table update on the resolve edge:
  - Entry tag, target and valid=1 are written only when actual=1.
  - ctr increments, saturating at 2'b11, if actual=1; otherwise it decrements, saturating at 2'b00.
  - A not-taken branch that misses the tag leaves the entry untouched.
- FSM has two states:
  - RUN: on resolve with mispredict, latch redirect_pc = actual ? ex_target : ex_pc + 4 (mod 2^PC_W) and go to FLUSH. Otherwise stay in RUN.
  - FLUSH: redirect_valid=1, flush=1 for exactly one cycle, regardless of stall; then return to RUN.
- EX inputs seen in FLUSH are wrong-path: no table update, no stats, no new redirect.
- Stall in RUN blocks resolve entirely, including the table update, so each instruction is counted once.
- Simultaneous lookup and update of the same index: lookup returns the pre-update contents; the new contents are visible from the next cycle.
- Reset mid-FLUSH: the FSM returns to RUN and all outputs and state return to reset values at that edge.

## Timing
- Reset values: redirect_valid=0, flush=0, redirect_pc=0, stat_*=0, state=RUN.
- Lookup latency is 0 cycles (same-cycle combinational).
- Mispredict resolved at edge N gives redirect_valid/flush high in cycle N+1 only; the earliest next resolve is at edge N+2.
- redirect_pc is registered and holds its value between redirects.
- Minimum spacing between redirects is 2 cycles.

## Configuration
- BRANCH_STATS_EN defined:
  - stat_branches increments on every resolve.
  - stat_mispredicts increments on every resolve with mispredict.
  - Both counters saturate at 32'hFFFF_FFFF and are cleared by rst.
- BRANCH_STATS_EN undefined: both ports are tied to 32'd0 and no counter flops are synthesized. Prediction behaviour is identical in both builds.

## Test plan
- Cold miss: after reset, resolve BEQ ex_pc=0x100, ex_taken=1, ex_target=0x140, ex_pred_taken=0. Required: next cycle redirect_valid=1, flush=1, redirect_pc=0x140. Then a lookup of if_pc=0x100 gives if_pred_taken=1, if_pred_target=0x140.
- Counter hysteresis: same branch resolved taken ×3 then not-taken ×1. Required: ctr 01→10→11→11→10; if_pred_taken is still 1 after the single not-taken resolve; redirect_pc=0x104 on that not-taken mispredict.
- Target mismatch: JAL ex_pc=0x200, ex_pred_taken=1, ex_pred_target=0x300, ex_target=0x340. Required: redirect to 0x340 and entry target updated to 0x340.
- Wrong-path and stall: hold stall=1 with a mispredicting EX for 3 cycles. Required: no redirect and no stat change. Drop stall: exactly one redirect. A second mispredict presented during FLUSH is ignored.
- Aliasing: entry written from 0x100, then lookup of 0x500 (same index, different tag). Required: if_pred_taken=0.
- Stats/reset: with BRANCH_STATS_EN, 5 resolves including 2 mispredicts give stat_branches=5, stat_mispredicts=2. Asserting rst during FLUSH clears redirect_valid and stats next cycle, and if_pred_taken=0 for 0x100.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped BTB with 2-bit counters plus EX-stage mispredict redirect/flush control.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_predict_ctrl #(
    parameter int IDX_W = 4,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] if_pc,
    output logic            if_pred_taken,
    output logic [PC_W-1:0] if_pred_target,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_jal,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [PC_W-1:0] ex_pred_target,
    input  logic            stall,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = PC_W - IDX_W - 2;
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t state, state_next;

    logic [ENTRIES-1:0] tbl_valid;
    logic [TAG_W-1:0]   tbl_tag    [ENTRIES];
    logic [PC_W-1:0]    tbl_target [ENTRIES];
    logic [1:0]         tbl_ctr    [ENTRIES];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;
    logic             resolve, actual, mispredict;
    logic             unused_ok;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[PC_W-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[PC_W-1:IDX_W+2];
    assign unused_ok = ^if_pc[1:0];

    // Lookup reads the registered table, so a same-cycle update is not yet visible.
    assign if_hit         = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag);
    assign if_pred_taken  = if_hit && tbl_ctr[if_idx][1];
    assign if_pred_target = if_pred_taken ? tbl_target[if_idx] : '0;

    assign ex_hit     = tbl_valid[ex_idx] && (tbl_tag[ex_idx] == ex_tag);
    assign resolve    = (state == RUN) && ex_valid && (ex_branch || ex_jal) && !stall;
    assign actual     = ex_jal ? 1'b1 : ex_taken;
    assign mispredict = (actual != ex_pred_taken) ||
                        (actual && ex_pred_taken && (ex_pred_target != ex_target));

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_tag[i]    <= '0;
                tbl_target[i] <= '0;
                tbl_ctr[i]    <= 2'b01;
            end
        end else if (resolve) begin
            if (actual) begin
                tbl_valid[ex_idx]  <= 1'b1;
                tbl_tag[ex_idx]    <= ex_tag;
                tbl_target[ex_idx] <= ex_target;
                tbl_ctr[ex_idx]    <= sat_inc(tbl_ctr[ex_idx]);
            end else if (ex_hit) begin
                tbl_ctr[ex_idx]    <= sat_dec(tbl_ctr[ex_idx]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            redirect_pc <= '0;
        end else begin
            state <= state_next;
            if (resolve && mispredict) begin
                redirect_pc <= actual ? ex_target : ex_pc + PC_STEP;
            end
        end
    end

    always_comb begin
        state_next     = state;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        case (state)
            RUN: begin
                if (resolve && mispredict) state_next = FLUSH;
            end
            FLUSH: begin
                redirect_valid = 1'b1;
                flush          = 1'b1;
                state_next     = RUN;
            end
            default: state_next = RUN;
        endcase
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt, mispredict_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (resolve) begin
            if (branch_cnt != 32'hFFFF_FFFF) branch_cnt <= branch_cnt + 32'd1;
            if (mispredict && (mispredict_cnt != 32'hFFFF_FFFF))
                mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

    assign stat_branches    = branch_cnt;
    assign stat_mispredicts = mispredict_cnt;
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl with a table-level reference model checked every cycle.
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid, ex_branch, ex_jal, ex_taken, ex_pred_taken, stall;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        redirect_valid, flush;
    logic [31:0] redirect_pc, stat_branches, stat_mispredicts;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predict_ctrl #(.IDX_W(4), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_taken(ex_taken),
        .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: 16 entries, counters as small integers.
    bit          m_valid  [16];
    logic [25:0] m_tag    [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];
    bit          m_flush, started;
    logic [31:0] m_rpc;
    int          m_br, m_mp;
    int          mi;
    bit          m_act, m_miss, m_hit;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
            end
            m_flush = 0; m_rpc = 0; m_br = 0; m_mp = 0; started = 1;
        end else if (m_flush) begin
            m_flush = 0;
        end else if (ex_valid && (ex_branch || ex_jal) && !stall) begin
            mi     = int'(ex_pc[5:2]);
            m_act  = ex_jal || ex_taken;
            m_miss = (m_act != ex_pred_taken) || (m_act && ex_target != ex_pred_target);
            m_hit  = m_valid[mi] && (m_tag[mi] == ex_pc[31:6]);
            if (m_act) begin
                m_valid[mi] = 1; m_tag[mi] = ex_pc[31:6]; m_target[mi] = ex_target;
                m_ctr[mi] = (m_ctr[mi] + 1 > 3) ? 3 : m_ctr[mi] + 1;
            end else if (m_hit) begin
                m_ctr[mi] = (m_ctr[mi] - 1 < 0) ? 0 : m_ctr[mi] - 1;
            end
            m_br++;
            if (m_miss) begin
                m_mp++;
                m_rpc   = m_act ? ex_target : ex_pc + 32'd4;
                m_flush = 1;
            end
        end
    end

    int          ci;
    bit          c_pt;
    logic [31:0] c_tg, c_sb, c_sm;

    always @(negedge clk) begin
        if (started) begin
            ci   = int'(if_pc[5:2]);
            c_pt = m_valid[ci] && (m_tag[ci] == if_pc[31:6]) && (m_ctr[ci] >= 2);
            c_tg = c_pt ? m_target[ci] : 32'd0;
`ifdef BRANCH_STATS_EN
            c_sb = m_br; c_sm = m_mp;
`else
            c_sb = 0; c_sm = 0;
`endif
            chk("cyc_pred_taken", {31'd0, if_pred_taken}, {31'd0, c_pt});
            chk("cyc_pred_target", if_pred_target, c_tg);
            chk("cyc_redirect_valid", {31'd0, redirect_valid}, {31'd0, m_flush});
            chk("cyc_flush", {31'd0, flush}, {31'd0, m_flush});
            chk("cyc_redirect_pc", redirect_pc, m_rpc);
            chk("cyc_stat_branches", stat_branches, c_sb);
            chk("cyc_stat_mispredicts", stat_mispredicts, c_sm);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic resolve(input bit br, input bit jal, input bit tk, input logic [31:0] pc,
                           input logic [31:0] tgt, input bit pt, input logic [31:0] ptg);
        ex_branch = br; ex_jal = jal; ex_taken = tk; ex_pc = pc; ex_target = tgt;
        ex_pred_taken = pt; ex_pred_target = ptg; ex_valid = 1;
        step();
        ex_valid = 0;
    endtask

    initial begin
        rst = 1; if_pc = 32'h100; stall = 0;
        ex_valid = 0; ex_branch = 0; ex_jal = 0; ex_taken = 0;
        ex_pc = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
        step(); step();
        rst = 0;
        chk("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);
        chk("reset_stat_branches", stat_branches, 32'd0);
        chk("reset_pred_taken", {31'd0, if_pred_taken}, 32'd0);

        // Cold miss
        resolve(1, 0, 1, 32'h100, 32'h140, 0, 32'h0);
        chk("cold_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("cold_flush", {31'd0, flush}, 32'd1);
        chk("cold_redirect_pc", redirect_pc, 32'h140);
        step();
        chk("cold_flush_one_cycle", {31'd0, flush}, 32'd0);
        chk("cold_lookup_taken", {31'd0, if_pred_taken}, 32'd1);
        chk("cold_lookup_target", if_pred_target, 32'h140);
        chk("model_ctr_after_cold", m_ctr[0], 32'd2);

        // Hysteresis: two more correct taken, then one not-taken
        resolve(1, 0, 1, 32'h100, 32'h140, 1, 32'h140);
        resolve(1, 0, 1, 32'h100, 32'h140, 1, 32'h140);
        chk("hyst_no_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("model_ctr_saturated", m_ctr[0], 32'd3);
        resolve(1, 0, 0, 32'h100, 32'h140, 1, 32'h140);
        chk("hyst_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("hyst_redirect_pc", redirect_pc, 32'h104);
        step();
        chk("model_ctr_after_nt", m_ctr[0], 32'd2);
        chk("hyst_still_taken", {31'd0, if_pred_taken}, 32'd1);

        // Aliasing: same index, different tag
        if_pc = 32'h500; #1;
        chk("alias_pred_taken", {31'd0, if_pred_taken}, 32'd0);
        chk("alias_pred_target", if_pred_target, 32'd0);

        // Target mismatch on JAL
        resolve(0, 1, 0, 32'h200, 32'h340, 1, 32'h300);
        chk("jal_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("jal_redirect_pc", redirect_pc, 32'h340);
        step();
        if_pc = 32'h200; #1;
        chk("jal_lookup_taken", {31'd0, if_pred_taken}, 32'd1);
        chk("jal_lookup_target", if_pred_target, 32'h340);
        if_pc = 32'h100; #1;
        chk("jal_evicts_0x100", {31'd0, if_pred_taken}, 32'd0);

        // Stall then wrong-path during FLUSH
        ex_branch = 1; ex_jal = 0; ex_taken = 1; ex_pc = 32'h184; ex_target = 32'h1c0;
        ex_pred_taken = 0; ex_pred_target = 0; ex_valid = 1; stall = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_no_redirect", {31'd0, redirect_valid}, 32'd0);
        end
        stall = 0;
        step();
        chk("unstall_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("unstall_redirect_pc", redirect_pc, 32'h1c0);
        ex_pc = 32'h188; ex_target = 32'h1f0;
        step();
        ex_valid = 0;
        chk("wrongpath_no_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("wrongpath_pc_held", redirect_pc, 32'h1c0);
        if_pc = 32'h188; #1;
        chk("wrongpath_no_update", {31'd0, if_pred_taken}, 32'd0);

        // Stats: fresh reset then five resolves with two mispredicts
        rst = 1; step(); rst = 0;
        resolve(1, 0, 1, 32'h100, 32'h140, 0, 32'h0); step();
        resolve(1, 0, 1, 32'h100, 32'h140, 1, 32'h140);
        resolve(1, 0, 0, 32'h104, 32'h180, 0, 32'h0);
        resolve(1, 0, 0, 32'h108, 32'h180, 0, 32'h0);
        resolve(0, 1, 0, 32'h10c, 32'h400, 0, 32'h0); step();
`ifdef BRANCH_STATS_EN
        chk("stats_branches", stat_branches, 32'd5);
        chk("stats_mispredicts", stat_mispredicts, 32'd2);
`else
        chk("stats_branches", stat_branches, 32'd0);
        chk("stats_mispredicts", stat_mispredicts, 32'd0);
`endif

        // Reset during FLUSH
        resolve(1, 0, 0, 32'h100, 32'h140, 1, 32'h140);
        chk("pre_reset_flush", {31'd0, flush}, 32'd1);
        rst = 1;
        step();
        chk("midflush_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("midflush_flush", {31'd0, flush}, 32'd0);
        chk("midflush_stat_branches", stat_branches, 32'd0);
        chk("midflush_redirect_pc", redirect_pc, 32'd0);
        if_pc = 32'h100; #1;
        chk("midflush_pred_taken", {31'd0, if_pred_taken}, 32'd0);
        rst = 0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
